// File: rtl/interp_fir_if.sv
// Sample stream bus for the interpolation FIR: one valid-qualified input
// sample and one valid-qualified output sample per clock.
interface interp_fir_if #(
  parameter int WIDTH = 32
);
  // Handshake: a beat transfers on any rising edge where its valid is 1.
  // There is no ready; both ends must accept every valid beat.
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic             out_valid;
  logic [WIDTH-1:0] y;

  modport master (output in_valid, output x, input out_valid, input y);
  modport slave  (input in_valid, input x, output out_valid, output y);
endinterface

// File: rtl/interp_fir.sv
// 4-tap pipelined FIR interpolation filter: multiply, sum, then round,
// arithmetic-shift and saturate back to WIDTH. Latency 2 edges, 1 sample/cycle.
module interp_fir #(
  parameter int                     WIDTH = 32,
  parameter int                     CW    = 16,
  parameter logic signed [CW-1:0]   C0    = 1,
  parameter logic signed [CW-1:0]   C1    = 2,
  parameter logic signed [CW-1:0]   C2    = 1,
  parameter logic signed [CW-1:0]   C3    = 0,
  parameter int                     SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  interp_fir_if.slave bus
);

  localparam int PW = WIDTH + CW;
  localparam int SW = PW + 2;
  // One guard bit above the sum so the rounding add can never wrap.
  localparam int RW = SW + 1;
  localparam logic signed [RW-1:0] RND  = (RW'(1) << SHIFT) >> 1;
  localparam logic [WIDTH-1:0]     MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic signed [PW-1:0]    p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic signed [SW-1:0]    sum_q, sum_d;
  logic                    v1_q, v1_d, v2_q, v2_d;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        y_q, y_d;

  logic signed [RW-1:0]    rnd;
  logic signed [RW-1:0]    shr;
  logic [RW-WIDTH:0]       top_bits;
  logic                    fits;
  logic [WIDTH-1:0]        sat;

  always_comb begin
    rnd      = RW'(sum_q) + RND;
    shr      = rnd >>> SHIFT;
    top_bits = shr[RW-1:WIDTH-1];
    // Value fits when every bit above the output MSB matches the sign.
    fits     = (&top_bits) | ~(|top_bits);
    if (fits) begin
      sat = shr[WIDTH-1:0];
    end else if (shr[RW-1]) begin
      sat = MINV;
    end else begin
      sat = MAXV;
    end
  end

  always_comb begin
    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    sum_d       = SW'(p0_q) + SW'(p1_q) + SW'(p2_q) + SW'(p3_q);
    v1_d        = bus.in_valid;
    v2_d        = v1_q;
    out_valid_d = v2_q;
    y_d         = y_q;

    if (bus.in_valid) begin
      p0_d = PW'($signed(bus.x)) * PW'(C0);
      p1_d = PW'(d1_q) * PW'(C1);
      p2_d = PW'(d2_q) * PW'(C2);
      p3_d = PW'(d3_q) * PW'(C3);
      d1_d = $signed(bus.x);
      d2_d = d1_q;
      d3_d = d2_q;
    end

    if (v2_q) begin
      y_d = sat;
    end

    // Clear wins over a sample presented in the same cycle.
    if (clr) begin
      d1_d        = '0;
      d2_d        = '0;
      d3_d        = '0;
      p0_d        = '0;
      p1_d        = '0;
      p2_d        = '0;
      p3_d        = '0;
      sum_d       = '0;
      v1_d        = 1'b0;
      v2_d        = 1'b0;
      out_valid_d = 1'b0;
      y_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      sum_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      sum_q       <= sum_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;

endmodule

// File: tb/tb_interp_fir.sv
// Directed bench for interp_fir: impulse, ramp, saturation, bubbles,
// clear priority and asynchronous reset, with an expected-value queue.
module tb_interp_fir;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  logic clr;

  interp_fir_if #(.WIDTH(W)) bus ();

  interp_fir dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  int n_checks;
  int n_errors;
  logic [W-1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: every valid output must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_out", bus.y, 32'hxxxx_xxxx);
      end else begin
        check_eq("sb_y", bus.y, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [W-1:0] xv);
    bus.in_valid = v;
    bus.x        = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.x        = '0;
    clr          = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_y", bus.y, '0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_drained(input string tag);
    check_eq(tag, 32'(exp_q.size()), 0);
  endtask

  logic [W-1:0] ramp_x[6]   = '{32'd10, 32'd0, 32'd11, 32'd0, 32'd12, 32'd0};
  logic [W-1:0] ramp_y[6]   = '{32'd5, 32'd10, 32'd11, 32'd11, 32'd12, 32'd12};
  logic [W-1:0] sat_x[6]    = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                32'h80000000, 32'h80000000, 32'h80000000};
  logic [W-1:0] sat_y[6]    = '{32'h40000000, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                32'h7FFFFFFF, 32'h80000000, 32'h80000000};
  logic         bub_v[12]   = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    #3;
    check_eq("async_rst_y", bus.y, '0);

    // impulse with latency checks
    do_reset();
    push_exp(5); push_exp(10); push_exp(5); push_exp(0); push_exp(0); push_exp(0);
    drive(1'b1, 32'd10);
    check_eq("imp_lat_k", 32'(bus.out_valid), 0);
    drive(1'b1, 32'd0);
    check_eq("imp_lat_k1", 32'(bus.out_valid), 0);
    drive(1'b1, 32'd0);
    check_eq("imp_lat_k2", 32'(bus.out_valid), 1);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'd0);
    idle(4);
    check_drained("imp_drained");

    // upsampled ramp
    do_reset();
    for (int i = 0; i < 6; i++) push_exp(ramp_y[i]);
    for (int i = 0; i < 6; i++) drive(1'b1, ramp_x[i]);
    idle(4);
    check_drained("ramp_drained");

    // saturation at both rails
    do_reset();
    for (int i = 0; i < 6; i++) push_exp(sat_y[i]);
    for (int i = 0; i < 6; i++) drive(1'b1, sat_x[i]);
    idle(4);
    check_drained("sat_drained");

    // bubbles: out_valid follows in_valid two edges later, y holds in gaps
    do_reset();
    push_exp(5); push_exp(10); push_exp(5); push_exp(0);
    begin
      logic [W-1:0] held;
      int           nv;
      held = '0;
      nv   = 0;
      for (int i = 0; i < 12; i++) begin
        drive(bub_v[i], (i == 0) ? 32'd10 : 32'd0);
        check_eq("bub_out_valid", 32'(bus.out_valid), (i >= 2) ? 32'(bub_v[i-2]) : 0);
        if (bus.out_valid) begin
          case (nv)
            0: held = 32'd5;
            1: held = 32'd10;
            2: held = 32'd5;
            default: held = 32'd0;
          endcase
          nv++;
        end else begin
          check_eq("bub_y_hold", bus.y, held);
        end
      end
    end
    check_drained("bub_drained");

    // clear priority: in-flight data and the sample beside clr are dropped
    do_reset();
    push_exp(4);
    drive(1'b1, 32'd7);
    drive(1'b1, 32'd3);
    drive(1'b1, 32'd9);
    clr = 1'b1;
    drive(1'b1, 32'd100);
    clr = 1'b0;
    check_eq("clr_y", bus.y, '0);
    check_eq("clr_out_valid", 32'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) push_exp(0);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'd0);
    idle(4);
    check_drained("clr_drained");

    // asynchronous reset between edges while out_valid is high
    do_reset();
    push_exp(5);
    drive(1'b1, 32'd10);
    drive(1'b1, 32'd0);
    drive(1'b1, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_y", bus.y, '0);
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check_drained("mid_rst_drained");
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(5); push_exp(10); push_exp(5);
    drive(1'b1, 32'd10);
    drive(1'b1, 32'd0);
    drive(1'b1, 32'd0);
    idle(4);
    check_drained("post_rst_drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
